// File: rtl/axilite_periph_arbiter_pkg.sv
// Shared types for the two-requester AXI-Lite peripheral arbiter: FSM state
// encodings and the 2-way round-robin pick rule.
package uninasoc_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } axilite_arb_wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } axilite_arb_rstate_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // A lone requester wins outright; a tie goes to the pointer's requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    else              gnt = req;
    return gnt;
  endfunction

endpackage

// File: rtl/axilite_periph_arbiter_if.sv
// AXI-Lite bundle (AW/W/B/AR/R) with master and slave views.
interface axilite_periph_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

endinterface

// File: rtl/axilite_periph_arbiter_rr.sv
// Two-requester round-robin arbiter: combinational pick, registered priority
// pointer that only moves when the owning transaction completes.
module rr_arbiter_2
  import uninasoc_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  assign gnt_o = rr_pick(req_i, ptr_q);

  // Point at whoever did not just finish, so each side waits at most one turn.
  always_comb begin
    ptr_d = ptr_q;
    if (done_i) ptr_d = ~done_idx_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axilite_periph_arbiter.sv
// Arbitrates two AXI-Lite requesters onto one peripheral port; write and read
// paths are independent, one outstanding transaction each, zero-latency muxing.
module axilite_periph_arbiter
  import uninasoc_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  axilite_periph_arbiter_if.slave        s0_axilite,
  axilite_periph_arbiter_if.slave        s1_axilite,
  axilite_periph_arbiter_if.master       m_axilite,
  output logic [1:0]                     wr_grant_o,
  output logic [1:0]                     rd_grant_o
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic run;
  assign run = ~reset_i;

  // ---------------- write path ----------------
  axilite_arb_wstate_t wstate_q, wstate_d;
  logic [1:0] wgnt_q, wgnt_d, warb_gnt, aw_req;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       m_awvalid, m_wvalid, m_bready, wr_cmpl;

  logic                      wsel;
  logic [AXI_ADDR_WIDTH-1:0] sel_awaddr;
  logic [2:0]                sel_awprot;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]         sel_wstrb;
  logic                      sel_awvalid, sel_wvalid, sel_bready;

  assign aw_req      = {s1_axilite.awvalid, s0_axilite.awvalid};
  assign wsel        = wgnt_q[1];
  assign sel_awaddr  = wsel ? s1_axilite.awaddr  : s0_axilite.awaddr;
  assign sel_awprot  = wsel ? s1_axilite.awprot  : s0_axilite.awprot;
  assign sel_awvalid = wsel ? s1_axilite.awvalid : s0_axilite.awvalid;
  assign sel_wdata   = wsel ? s1_axilite.wdata   : s0_axilite.wdata;
  assign sel_wstrb   = wsel ? s1_axilite.wstrb   : s0_axilite.wstrb;
  assign sel_wvalid  = wsel ? s1_axilite.wvalid  : s0_axilite.wvalid;
  assign sel_bready  = wsel ? s1_axilite.bready  : s0_axilite.bready;

  rr_arbiter_2 u_wr_arb (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .req_i      (aw_req),
    .done_i     (wr_cmpl),
    .done_idx_i (wsel),
    .gnt_o      (warb_gnt)
  );

  always_comb begin
    wstate_d  = wstate_q;
    wgnt_d    = wgnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    wr_cmpl   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (|aw_req) begin
          wstate_d = W_ADDR;
          wgnt_d   = warb_gnt;
        end
      end
      W_ADDR: begin
        // AW and W retire independently; each is masked once it has handshaked.
        m_awvalid = sel_awvalid & ~aw_done_q;
        m_wvalid  = sel_wvalid  & ~w_done_q;
        aw_done_d = aw_done_q | (m_awvalid & m_axilite.awready);
        w_done_d  = w_done_q  | (m_wvalid  & m_axilite.wready);
        if (aw_done_d && w_done_d) begin
          wstate_d  = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        m_bready = sel_bready;
        if (m_axilite.bvalid && sel_bready) begin
          wstate_d = W_IDLE;
          wgnt_d   = 2'b00;
          wr_cmpl  = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wstate_q  <= W_IDLE;
      wgnt_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      wgnt_q    <= wgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---------------- read path ----------------
  axilite_arb_rstate_t rstate_q, rstate_d;
  logic [1:0] rgnt_q, rgnt_d, rarb_gnt, ar_req;
  logic       m_arvalid, m_rready, rd_cmpl;

  logic                      rsel;
  logic [AXI_ADDR_WIDTH-1:0] sel_araddr;
  logic [2:0]                sel_arprot;
  logic                      sel_arvalid, sel_rready;

  assign ar_req      = {s1_axilite.arvalid, s0_axilite.arvalid};
  assign rsel        = rgnt_q[1];
  assign sel_araddr  = rsel ? s1_axilite.araddr  : s0_axilite.araddr;
  assign sel_arprot  = rsel ? s1_axilite.arprot  : s0_axilite.arprot;
  assign sel_arvalid = rsel ? s1_axilite.arvalid : s0_axilite.arvalid;
  assign sel_rready  = rsel ? s1_axilite.rready  : s0_axilite.rready;

  rr_arbiter_2 u_rd_arb (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .req_i      (ar_req),
    .done_i     (rd_cmpl),
    .done_idx_i (rsel),
    .gnt_o      (rarb_gnt)
  );

  always_comb begin
    rstate_d  = rstate_q;
    rgnt_d    = rgnt_q;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rd_cmpl   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (|ar_req) begin
          rstate_d = R_ADDR;
          rgnt_d   = rarb_gnt;
        end
      end
      R_ADDR: begin
        m_arvalid = sel_arvalid;
        if (m_arvalid && m_axilite.arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        m_rready = sel_rready;
        if (m_axilite.rvalid && sel_rready) begin
          rstate_d = R_IDLE;
          rgnt_d   = 2'b00;
          rd_cmpl  = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rstate_q <= R_IDLE;
      rgnt_q   <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rgnt_q   <= rgnt_d;
    end
  end

  // ---------------- downstream port ----------------
  assign m_axilite.awaddr  = sel_awaddr;
  assign m_axilite.awprot  = sel_awprot;
  assign m_axilite.awvalid = m_awvalid & run;
  assign m_axilite.wdata   = sel_wdata;
  assign m_axilite.wstrb   = sel_wstrb;
  assign m_axilite.wvalid  = m_wvalid & run;
  assign m_axilite.bready  = m_bready & run;
  assign m_axilite.araddr  = sel_araddr;
  assign m_axilite.arprot  = sel_arprot;
  assign m_axilite.arvalid = m_arvalid & run;
  assign m_axilite.rready  = m_rready & run;

  // ---------------- upstream ports: only the owner sees handshakes ----------------
  logic w_resp, r_data;
  assign w_resp = (wstate_q == W_RESP);
  assign r_data = (rstate_q == R_DATA);

  assign s0_axilite.awready = wgnt_q[0] & m_awvalid & m_axilite.awready & run;
  assign s1_axilite.awready = wgnt_q[1] & m_awvalid & m_axilite.awready & run;
  assign s0_axilite.wready  = wgnt_q[0] & m_wvalid  & m_axilite.wready  & run;
  assign s1_axilite.wready  = wgnt_q[1] & m_wvalid  & m_axilite.wready  & run;
  assign s0_axilite.bvalid  = wgnt_q[0] & w_resp & m_axilite.bvalid & run;
  assign s1_axilite.bvalid  = wgnt_q[1] & w_resp & m_axilite.bvalid & run;
  assign s0_axilite.bresp   = m_axilite.bresp;
  assign s1_axilite.bresp   = m_axilite.bresp;

  assign s0_axilite.arready = rgnt_q[0] & m_arvalid & m_axilite.arready & run;
  assign s1_axilite.arready = rgnt_q[1] & m_arvalid & m_axilite.arready & run;
  assign s0_axilite.rvalid  = rgnt_q[0] & r_data & m_axilite.rvalid & run;
  assign s1_axilite.rvalid  = rgnt_q[1] & r_data & m_axilite.rvalid & run;
  assign s0_axilite.rdata   = m_axilite.rdata;
  assign s1_axilite.rdata   = m_axilite.rdata;
  assign s0_axilite.rresp   = m_axilite.rresp;
  assign s1_axilite.rresp   = m_axilite.rresp;

  assign wr_grant_o = wgnt_q & {2{run}};
  assign rd_grant_o = rgnt_q & {2{run}};

endmodule

// File: tb/tb_axilite_periph_arbiter.sv
// Self-checking bench: two randomized requesters, a memory-backed downstream
// slave, and a reference memory that predicts every read and response.
module tb_axilite_periph_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axilite_periph_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axilite_periph_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axilite_periph_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  logic [1:0] wr_grant, rd_grant;

  axilite_periph_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .clock_i(clk), .reset_i(rst),
    .s0_axilite(s0_if), .s1_axilite(s1_if), .m_axilite(m_if),
    .wr_grant_o(wr_grant), .rd_grant_o(rd_grant)
  );

  // requester-side drive arrays
  logic [1:0]  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [31:0] awaddr_d [2], wdata_d [2], araddr_d [2];
  logic [3:0]  wstrb_d [2];
  logic [2:0]  awprot_d [2], arprot_d [2];
  logic [1:0]  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]  bresp_r [2], rresp_r [2];
  logic [31:0] rdata_r [2];

  assign s0_if.awaddr = awaddr_d[0]; assign s1_if.awaddr = awaddr_d[1];
  assign s0_if.awprot = awprot_d[0]; assign s1_if.awprot = awprot_d[1];
  assign s0_if.awvalid = awvalid_d[0]; assign s1_if.awvalid = awvalid_d[1];
  assign s0_if.wdata = wdata_d[0]; assign s1_if.wdata = wdata_d[1];
  assign s0_if.wstrb = wstrb_d[0]; assign s1_if.wstrb = wstrb_d[1];
  assign s0_if.wvalid = wvalid_d[0]; assign s1_if.wvalid = wvalid_d[1];
  assign s0_if.bready = bready_d[0]; assign s1_if.bready = bready_d[1];
  assign s0_if.araddr = araddr_d[0]; assign s1_if.araddr = araddr_d[1];
  assign s0_if.arprot = arprot_d[0]; assign s1_if.arprot = arprot_d[1];
  assign s0_if.arvalid = arvalid_d[0]; assign s1_if.arvalid = arvalid_d[1];
  assign s0_if.rready = rready_d[0]; assign s1_if.rready = rready_d[1];
  assign awready_r = {s1_if.awready, s0_if.awready};
  assign wready_r  = {s1_if.wready,  s0_if.wready};
  assign bvalid_r  = {s1_if.bvalid,  s0_if.bvalid};
  assign arready_r = {s1_if.arready, s0_if.arready};
  assign rvalid_r  = {s1_if.rvalid,  s0_if.rvalid};
  assign bresp_r[0] = s0_if.bresp; assign bresp_r[1] = s1_if.bresp;
  assign rresp_r[0] = s0_if.rresp; assign rresp_r[1] = s1_if.rresp;
  assign rdata_r[0] = s0_if.rdata; assign rdata_r[1] = s1_if.rdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory rules shared by the downstream slave and the reference model
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[4] ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- downstream slave ----------------
  logic [31:0] ds_mem [logic [31:0]];
  logic        hold_b = 1'b0;
  logic [31:0] lw_addr, lw_data, lr_addr;
  logic [3:0]  lw_strb;
  logic [2:0]  lw_prot, lr_prot;
  int          wr_txn_cnt = 0;

  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, rst_s;
    logic [31:0] a_aw, a_w, a_ar, old;
    logic [3:0]  a_s;
    logic [2:0]  p_aw, p_ar;
    got_aw = 0; got_w = 0;
    a_aw = '0; a_w = '0; a_ar = '0; a_s = '0; p_aw = '0; p_ar = '0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      aw_hs = m_if.awvalid && m_if.awready;
      w_hs  = m_if.wvalid && m_if.wready;
      b_hs  = m_if.bvalid && m_if.bready;
      ar_hs = m_if.arvalid && m_if.arready;
      r_hs  = m_if.rvalid && m_if.rready;
      if (aw_hs) begin a_aw = m_if.awaddr; p_aw = m_if.awprot; end
      if (w_hs)  begin a_w = m_if.wdata; a_s = m_if.wstrb; end
      if (ar_hs) begin a_ar = m_if.araddr; p_ar = m_if.arprot; end
      @(posedge clk); #1;
      if (rst_s) begin
        got_aw = 0; got_w = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.arready = 0; m_if.rvalid = 0;
      end else begin
        if (aw_hs) got_aw = 1;
        if (w_hs)  got_w = 1;
        if (b_hs)  m_if.bvalid = 0;
        if (r_hs)  m_if.rvalid = 0;
        if (got_aw && got_w && !m_if.bvalid && !hold_b) begin
          old = ds_mem.exists(a_aw) ? ds_mem[a_aw] : dflt(a_aw);
          ds_mem[a_aw] = merge(old, a_w, a_s);
          lw_addr = a_aw; lw_data = a_w; lw_strb = a_s; lw_prot = p_aw;
          m_if.bvalid = 1; m_if.bresp = resp_of(a_aw);
          got_aw = 0; got_w = 0;
          wr_txn_cnt++;
        end
        if (ar_hs) begin
          m_if.rvalid = 1;
          m_if.rdata  = ds_mem.exists(a_ar) ? ds_mem[a_ar] : dflt(a_ar);
          m_if.rresp  = resp_of(a_ar);
          lr_addr = a_ar; lr_prot = p_ar;
        end
        m_if.awready = !got_aw && ($urandom_range(0, 3) != 0);
        m_if.wready  = !got_w  && ($urandom_range(0, 3) != 0);
        m_if.arready = !m_if.rvalid && ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- reference model + requester tasks ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [1:0]  wr_active = 2'b00, rd_active = 2'b00;
  int          wr_order [$];
  int          rd_order [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic do_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int w_lead);
    logic awh, wh, bh, b_ok;
    logic [2:0] p;
    int cyc;
    p = 3'($urandom_range(0, 7));
    wr_active[i] = 1;
    awaddr_d[i] = a; wdata_d[i] = d; wstrb_d[i] = s; awprot_d[i] = p; bready_d[i] = 1;
    if (w_lead > 0) begin
      wvalid_d[i] = 1;
      repeat (w_lead) begin
        @(negedge clk); check("w_lead_no_wready", wready_r[i], 1'b0);
        @(posedge clk); #1;
      end
    end
    awvalid_d[i] = 1; wvalid_d[i] = 1;
    b_ok = 0; cyc = 0;
    while (!b_ok && cyc < 300) begin
      @(negedge clk);
      awh = awvalid_d[i] && awready_r[i];
      wh  = wvalid_d[i] && wready_r[i];
      bh  = bvalid_r[i] && bready_d[i];
      if (bh) begin
        check("wr_bresp", bresp_r[i], resp_of(a));
        check("wr_m_addr", lw_addr, a);
        check("wr_m_data", lw_data, d);
        check("wr_m_strb", lw_strb, s);
        check("wr_m_prot", lw_prot, p);
      end
      @(posedge clk); #1;
      if (awh) awvalid_d[i] = 0;
      if (wh)  wvalid_d[i] = 0;
      if (bh)  begin b_ok = 1; bready_d[i] = 0; end
      cyc++;
    end
    check("wr_completes", b_ok, 1'b1);
    if (b_ok) begin
      ref_mem[a] = merge(ref_rd(a), d, s);
      wr_order.push_back(i);
    end
    awvalid_d[i] = 0; wvalid_d[i] = 0; bready_d[i] = 0;
    wr_active[i] = 0;
  endtask

  task automatic do_rd(input int i, input logic [31:0] a);
    logic arh, rh, r_ok;
    logic [2:0] p;
    int cyc;
    p = 3'($urandom_range(0, 7));
    rd_active[i] = 1;
    araddr_d[i] = a; arprot_d[i] = p; arvalid_d[i] = 1; rready_d[i] = 1;
    r_ok = 0; cyc = 0;
    while (!r_ok && cyc < 300) begin
      @(negedge clk);
      arh = arvalid_d[i] && arready_r[i];
      rh  = rvalid_r[i] && rready_d[i];
      if (rh) begin
        check("rd_data", rdata_r[i], ref_rd(a));
        check("rd_rresp", rresp_r[i], resp_of(a));
        check("rd_m_addr", lr_addr, a);
        check("rd_m_prot", lr_prot, p);
      end
      @(posedge clk); #1;
      if (arh) arvalid_d[i] = 0;
      if (rh)  begin r_ok = 1; rready_d[i] = 0; end
      cyc++;
    end
    check("rd_completes", r_ok, 1'b1);
    if (r_ok) rd_order.push_back(i);
    arvalid_d[i] = 0; rready_d[i] = 0;
    rd_active[i] = 0;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
                awready_r, wready_r, bvalid_r, arready_r, rvalid_r, wr_grant, rd_grant}, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) begin
      @(negedge clk); check_quiet("rst_quiet");
      @(posedge clk); #1;
    end
    rst = 0;
    @(negedge clk); check_quiet("post_rst_quiet");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] raddr(input int i);
    return (i == 0 ? 32'h1000_0000 : 32'h3000_0000) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt0, cnt1, txn0;
    logic seen, awh, wh;
    awvalid_d = 0; wvalid_d = 0; bready_d = 0; arvalid_d = 0; rready_d = 0;
    for (int i = 0; i < 2; i++) begin
      awaddr_d[i] = 0; wdata_d[i] = 0; araddr_d[i] = 0; wstrb_d[i] = 0;
      awprot_d[i] = 0; arprot_d[i] = 0;
    end

    // exclusivity monitor: a requester with nothing outstanding sees no handshake
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          if (!wr_active[i]) check("w_idle_quiet", {awready_r[i], wready_r[i], bvalid_r[i]}, 3'b000);
          if (!rd_active[i]) check("r_idle_quiet", {arready_r[i], rvalid_r[i]}, 2'b00);
        end
        check("grant_not_both", {&wr_grant, &rd_grant}, 2'b00);
      end
    join_none

    do_reset(3);

    // lone s0 write: registered grant, then release
    fork
      do_wr(0, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 0);
      begin
        @(negedge clk); check("t31_no_awvalid_c0", {m_if.awvalid, wr_grant}, 3'b000);
        @(negedge clk);
        check("t31_awvalid_c1", m_if.awvalid, 1'b1);
        check("t31_grant", wr_grant, 2'b01);
        check("t31_addr", m_if.awaddr, 32'h1000_0000);
        check("t31_data", m_if.wdata, 32'hDEAD_BEEF);
      end
    join
    @(negedge clk); check("t31_grant_release", wr_grant, 2'b00);
    @(posedge clk); #1;

    // simultaneous writes after reset: s0 first, then s1
    do_reset(1);
    wr_order.delete();
    fork
      do_wr(0, 32'h1000_0008, 32'h1111_2222, 4'hF, 0);
      do_wr(1, 32'h3000_0008, 32'h3333_4444, 4'hF, 0);
      begin
        @(negedge clk); @(negedge clk);
        check("t32_first_grant", wr_grant, 2'b01);
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
          @(negedge clk); if (wr_grant == 2'b10) seen = 1;
        end
        check("t32_second_grant_s1", seen, 1'b1);
      end
    join
    check("t32_order_len", wr_order.size(), 2);
    if (wr_order.size() == 2) begin
      check("t32_order0", wr_order[0], 0);
      check("t32_order1", wr_order[1], 1);
    end

    // W leads AW by 3 cycles on s1: exactly one downstream write
    txn0 = wr_txn_cnt;
    fork
      do_wr(1, 32'h3000_0010, 32'hCAFE_F00D, 4'h5, 3);
      repeat (3) begin @(negedge clk); check("t33_no_m_wvalid", m_if.wvalid, 1'b0); end
    join
    check("t33_one_txn", wr_txn_cnt - txn0, 1);

    // concurrent s0 read and s1 write
    fork
      do_rd(0, 32'h2000_0004);
      do_wr(1, 32'h3000_0014, 32'h0BAD_CAFE, 4'hF, 0);
      begin
        @(negedge clk); @(negedge clk);
        check("t34_rd_grant", rd_grant, 2'b01);
        check("t34_wr_grant", wr_grant, 2'b10);
      end
    join

    // continuous reads from both: strict alternation starting with s0
    do_reset(1);
    rd_order.delete();
    fork
      for (int k = 0; k < 4; k++) do_rd(0, raddr(0));
      for (int k = 0; k < 4; k++) do_rd(1, raddr(1));
    join
    check("t35_count", rd_order.size(), 8);
    cnt0 = 0; cnt1 = 0;
    foreach (rd_order[k]) begin
      check("t35_alternate", rd_order[k], k % 2);
      if (rd_order[k] == 0) cnt0++; else cnt1++;
      check("t35_balance", (cnt0 - cnt1 <= 1) && (cnt1 - cnt0 <= 1), 1'b1);
    end

    // reset while waiting for B: everything quiet, then s1 write works
    hold_b = 1;
    wr_active[0] = 1;
    awaddr_d[0] = 32'h1000_0040; wdata_d[0] = 32'h7777_8888; wstrb_d[0] = 4'hF;
    awprot_d[0] = 3'd0; awvalid_d[0] = 1; wvalid_d[0] = 1; bready_d[0] = 1;
    for (int k = 0; k < 100 && (awvalid_d[0] || wvalid_d[0]); k++) begin
      @(negedge clk);
      awh = awvalid_d[0] && awready_r[0];
      wh  = wvalid_d[0] && wready_r[0];
      @(posedge clk); #1;
      if (awh) awvalid_d[0] = 0;
      if (wh)  wvalid_d[0] = 0;
    end
    check("t36_addr_phase_done", {awvalid_d[0], wvalid_d[0]}, 2'b00);
    awvalid_d[0] = 0; wvalid_d[0] = 0;
    @(negedge clk); check("t36_b_held", bvalid_r[0], 1'b0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk); check_quiet("t36_rst_quiet");
    @(posedge clk); #1;
    rst = 0; bready_d[0] = 0; wr_active[0] = 0; hold_b = 0;
    @(negedge clk); check_quiet("t36_post_rst_quiet");
    @(posedge clk); #1;
    do_wr(1, 32'h3000_0020, 32'h1234_5678, 4'hF, 0);
    do_rd(1, 32'h3000_0020);

    // random mixed traffic, each requester in its own address region
    for (int it = 0; it < 16; it++) begin
      fork
        for (int k = 0; k < 3; k++)
          if ($urandom_range(0, 1) != 0) do_wr(0, raddr(0), $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
          else do_rd(0, raddr(0));
        for (int k = 0; k < 3; k++)
          if ($urandom_range(0, 1) != 0) do_wr(1, raddr(1), $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
          else do_rd(1, raddr(1));
      join
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
